instr_fetch: RTL



---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_next_pc.sv | 35 +++
 rtl/instr_fetch.sv | 98 +++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Core-wide fetch definitions: the fetch FSM encoding, the NOP word and the
// MIPS opcode values that downstream control (and checking) keys on.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } fetch_state_e;

  // SLL $0,$0,0 encodes as all zeros and is the architectural NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  // Branch immediates are 16-bit two's complement word offsets
  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Next-PC arithmetic for the fetch stage: sequential, branch and jump targets
// plus the priority select. Purely combinational; all sums wrap modulo 2^32.
module next_pc_calc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] instr_index_i,
  input  logic        pc_src_i,
  input  logic        jump_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4_o = pc_i + 32'd4;

  // Branch offset counts words relative to the delay-slot address (pc + 4)
  assign branch_target = pc_plus4_o + (sign_ext16(instr_index_i[15:0]) << 2);

  // J-type keeps the 256 MB region of pc + 4 and replaces the low 28 bits
  assign jump_target = {pc_plus4_o[31:28], instr_index_i, 2'b00};

  // A jump overrides a simultaneously asserted branch-taken signal
  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jump_i) begin
      next_pc_o = jump_target;
    end else if (pc_src_i) begin
      next_pc_o = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage of the MIPS core. Holds the PC, fetches one word at a time from
// instruction memory over req/ack, presents it to control for one EXEC cycle
// (longer while stalled) and then advances the PC from control's decision.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_src,
  input  logic        jump,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  next_pc;

  next_pc_calc u_next_pc (
    .pc_i          (pc_q),
    .instr_index_i (instr_q[25:0]),
    .pc_src_i      (pc_src),
    .jump_i        (jump),
    .pc_plus4_o    (pc_plus4),
    .next_pc_o     (next_pc)
  );

  // The request is decoded from state so it drops the instant reset asserts
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = {pc_q[31:2], 2'b00};
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];

  // State and datapath registers; reset returns to BOOT at the aligned reset PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Fetch sequencing: one idle BOOT cycle, wait for ack, execute, advance PC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      BOOT: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule
